// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signals of the SRAM arbiter, bundled so the arbiter (slave)
// and its environment (master) connect through one port.
interface sram_arbiter_if #(
   parameter int unsigned BURST = 64,
   parameter int unsigned PIX_W = 24
);
   localparam int unsigned DW = BURST * PIX_W;

   logic          wr_req;
   logic [23:0]   wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_done;
   logic          rd_req;
   logic [23:0]   rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_done;
   logic          clr_req;
   logic          clr_done;
   logic          addr_err;
   logic          busy;
   logic [23:0]   sram_addr;
   logic [DW-1:0] sram_wdata;
   logic          sram_we;
   logic          sram_re;
   logic          sram_clr;
   logic [DW-1:0] sram_rdata;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_req, sram_rdata,
      output wr_done, rd_data, rd_done, clr_done, addr_err, busy,
             sram_addr, sram_wdata, sram_we, sram_re, sram_clr
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_req, sram_rdata,
      input  wr_done, rd_data, rd_done, clr_done, addr_err, busy,
             sram_addr, sram_wdata, sram_we, sram_re, sram_clr
   );
endinterface

// File: rtl/sram_arbiter.sv
// SRAM arbiter: serialises render writes, display reads and memory clears onto one
// burst-wide SRAM port; clear wins, writes and reads alternate when both are pending.
module sram_arbiter #(
   parameter int unsigned MEM_DEPTH = 208896,
   parameter int unsigned BURST     = 64,
   parameter int unsigned PIX_W     = 24
) (
   input logic           clk,
   input logic           n_rst,
   sram_arbiter_if.slave bus
);
   localparam int unsigned DW        = BURST * PIX_W;
   localparam logic [24:0] LAST_ADDR = 25'(MEM_DEPTH - BURST);

   typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, CLEAR, DONE} state_e;

   state_e        r_state;
   logic          r_rr_rd;
   logic          r_we;
   logic          r_re;
   logic          r_clr;
   logic          r_wr_done;
   logic          r_rd_done;
   logic          r_clr_done;
   logic          r_addr_err;
   logic [23:0]   r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rd_data;

   logic w_wr_ok;
   logic w_rd_ok;
   logic w_pick_rd;

   // Widened compare so addresses near 2^24 cannot wrap into the valid range
   assign w_wr_ok   = ({1'b0, bus.wr_addr} <= LAST_ADDR);
   assign w_rd_ok   = ({1'b0, bus.rd_addr} <= LAST_ADDR);
   assign w_pick_rd = bus.rd_req & (~bus.wr_req | r_rr_rd);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= IDLE;
         r_rr_rd    <= 1'b1;
         r_we       <= 1'b0;
         r_re       <= 1'b0;
         r_clr      <= 1'b0;
         r_wr_done  <= 1'b0;
         r_rd_done  <= 1'b0;
         r_clr_done <= 1'b0;
         r_addr_err <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_data  <= '0;
      end else begin
         // Enables and completions are single-cycle pulses
         r_we       <= 1'b0;
         r_re       <= 1'b0;
         r_clr      <= 1'b0;
         r_wr_done  <= 1'b0;
         r_rd_done  <= 1'b0;
         r_clr_done <= 1'b0;
         r_addr_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.clr_req) begin
                  r_clr   <= 1'b1;
                  r_state <= CLEAR;
               end else if (w_pick_rd) begin
                  r_rr_rd <= 1'b0;
                  if (w_rd_ok) begin
                     r_re    <= 1'b1;
                     r_addr  <= bus.rd_addr;
                     r_state <= READ;
                  end else begin
                     r_addr_err <= 1'b1;
                     r_rd_done  <= 1'b1;
                     r_state    <= DONE;
                  end
               end else if (bus.wr_req) begin
                  r_rr_rd <= 1'b1;
                  if (w_wr_ok) begin
                     r_we    <= 1'b1;
                     r_addr  <= bus.wr_addr;
                     r_wdata <= bus.wr_data;
                     r_state <= WRITE;
                  end else begin
                     r_addr_err <= 1'b1;
                     r_wr_done  <= 1'b1;
                     r_state    <= DONE;
                  end
               end
            end
            WRITE: begin
               r_wr_done <= 1'b1;
               r_state   <= DONE;
            end
            READ: begin
               r_state <= RWAIT;
            end
            RWAIT: begin
               r_rd_data <= bus.sram_rdata;
               r_rd_done <= 1'b1;
               r_state   <= DONE;
            end
            CLEAR: begin
               r_clr_done <= 1'b1;
               r_state    <= DONE;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = (r_state != IDLE);
   assign bus.sram_we    = r_we;
   assign bus.sram_re    = r_re;
   assign bus.sram_clr   = r_clr;
   assign bus.sram_addr  = r_addr;
   assign bus.sram_wdata = r_wdata;
   assign bus.wr_done    = r_wr_done;
   assign bus.rd_done    = r_rd_done;
   assign bus.clr_done   = r_clr_done;
   assign bus.addr_err   = r_addr_err;
   assign bus.rd_data    = r_rd_data;
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 208896, meaning the number of 24-bit words in the attached SRAM.
REQ-002 The block SHALL have parameter BURST, default 64, meaning the number of words per access.
REQ-003 The block SHALL have parameter PIX_W, default 24, meaning the bits per word.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports wr_req (in, 1), wr_addr (in, 24) and wr_data (in, BURST*PIX_W): the render write request, start word address and burst data.
REQ-007 The block SHALL have port wr_done, output, 1 bit: a one-cycle pulse that ends a write transaction.
REQ-008 The block SHALL have ports rd_req (in, 1) and rd_addr (in, 24): the display read request and start word address.
REQ-009 The block SHALL have ports rd_data (out, BURST*PIX_W) and rd_done (out, 1): the read result and a one-cycle completion pulse.
REQ-010 The block SHALL have ports clr_req (in, 1) and clr_done (out, 1): the memory-clear request and a one-cycle completion pulse.
REQ-011 The block SHALL have port addr_err, output, 1 bit: a one-cycle pulse when a rejected address is seen.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have SRAM-side ports sram_addr (out, 24), sram_wdata (out, BURST*PIX_W), sram_we (out, 1), sram_re (out, 1), sram_clr (out, 1) and sram_rdata (in, BURST*PIX_W).

Function
REQ-014 The FSM SHALL have states IDLE, WRITE, READ, RWAIT, CLEAR and DONE.
REQ-015 Requester handshake: a requester holds req, addr and data stable until its done pulse, then drops req in the done cycle.
REQ-016 The arbiter SHALL ignore a requester's req in the cycle its own done is high.
REQ-017 In IDLE, priority SHALL be clr_req first, then wr_req versus rd_req in round-robin order.
REQ-018 The round-robin flag SHALL favour the port not granted most recently; after reset it favours rd.
REQ-019 Round-robin SHALL apply only when wr_req and rd_req are both high; a single requester is granted immediately.
REQ-020 On grant, sram_addr and sram_wdata SHALL be registered from the winner's inputs; later input changes have no effect on the transaction.
REQ-021 Address check: an address is valid iff addr <= MEM_DEPTH-BURST, compared at 25-bit width with no wrap-around.
REQ-022 On an invalid address: no SRAM enable; addr_err and the requester's done both pulse in cycle k+1, where k is the sampling edge; round-robin flag updated as for a grant.
REQ-023 Write timing: wr_req sampled at edge k; WRITE occupies cycle k+1 with sram_we=1; wr_done=1 in cycle k+2 (DONE); FSM returns to IDLE at the end of k+2.
REQ-024 Read timing: rd_req sampled at edge k; READ occupies cycle k+1 with sram_re=1; RWAIT occupies cycle k+2 while sram_rdata is valid.
REQ-025 Read completion: rd_data SHALL capture sram_rdata at the end of k+2; rd_done=1 in cycle k+3 (DONE).
REQ-026 rd_data SHALL hold its value until the next successful read completes.
REQ-027 Clear: CLEAR occupies cycle k+1 with sram_clr=1; clr_done=1 in cycle k+2.
REQ-028 sram_we, sram_re and sram_clr SHALL be mutually exclusive, each high for exactly one cycle per transaction, and all registered outputs.
REQ-029 Throughput SHALL be at most one transaction every 3 cycles for write/clear and every 4 cycles for read; DONE returns to IDLE with no extra idle cycle.

Reset
REQ-030 While n_rst=0, the FSM SHALL be IDLE and every output SHALL be 0, including rd_data and sram_addr; the round-robin flag favours rd.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately with no done pulse, and SRAM enables SHALL drop asynchronously.
REQ-032 After n_rst rises, the first sampling edge SHALL be the next rising clk edge.

Verification
REQ-033 Write then read back: wr_req, wr_addr=0x000100, wr_data word i = i+1 -> sram_we for one cycle, wr_done at k+2; then rd_req, rd_addr=0x000100 -> rd_done at k+3 with rd_data word i = i+1.
REQ-034 Contention: wr_req and rd_req both rise in the same cycle right after reset -> read granted first, write next; wr_done/rd_done never coincide; no enable overlap.
REQ-035 Clear priority: clr_req, wr_req and rd_req all high in IDLE -> sram_clr first, clr_done at k+2, then round-robin service of the other two.
REQ-036 Boundary address: rd_addr=208832 -> normal read; rd_addr=208833 -> addr_err and rd_done at k+1, sram_re never asserted; wr_addr=0xFFFFFF -> addr_err.
REQ-037 Reset mid-read: n_rst low during RWAIT -> outputs 0 asynchronously, no rd_done; after release, a fresh read completes normally.
REQ-038 Held request: wr_req held high across its done cycle -> exactly one write per done cycle, and a second write starts only from the following IDLE sample.
